// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: 2-flop synchronizers, 11-bit frame FSM with edge timeout, FWFT byte FIFO.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity checking (parity_err); otherwise parity is ignored.
module ps2_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic [4:0] fifo_count,
    output logic       overflow,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0]    LAST_BIT = 4'd9;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]    FULL_CNT = 5'(FIFO_DEPTH);

    logic          clk_s1_q, clk_s1_d;
    logic          clk_s2_q, clk_s2_d;
    logic          clk_prev_q, clk_prev_d;
    logic          dat_s1_q, dat_s1_d;
    logic          dat_s2_q, dat_s2_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    sh_q, sh_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          fall;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          full;

`ifdef PS2_PARITY_CHECK_EN
    logic          parity_err_q, parity_err_d;
`else
    logic          parity_unused;
    assign parity_unused = sh_q[8];
`endif

    assign fall = clk_prev_q & ~clk_s2_q;

    // Frame FSM. to_cnt holds cycles elapsed since the last accepted edge.
    always_comb begin
        clk_s1_d    = ps2_clk;
        clk_s2_d    = clk_s1_q;
        clk_prev_d  = clk_s2_q;
        dat_s1_d    = ps2_dat;
        dat_s2_d    = dat_s1_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        to_cnt_d    = to_cnt_q;
        frame_err_d = 1'b0;
        push_req    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                to_cnt_d = '0;
                if (fall && !dat_s2_q) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    sh_d      = '0;
                    to_cnt_d  = TW'(1);
                end
            end
            ST_SHIFT: begin
                if (fall) begin
                    sh_d     = {dat_s2_q, sh_q[9:1]};
                    to_cnt_d = TW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    sh_d        = '0;
                    bit_cnt_d   = '0;
                    to_cnt_d    = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                to_cnt_d  = '0;
                sh_d      = '0;
                // sh_q[9] is the stop bit, sh_q[8] parity, sh_q[7:0] the byte.
                if (!sh_q[9]) begin
                    frame_err_d = 1'b1;
                end
`ifdef PS2_PARITY_CHECK_EN
                else if (!(^sh_q[8:0])) begin
                    parity_err_d = 1'b1;
                end
`endif
                else begin
                    push_req = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                to_cnt_d  = '0;
                sh_d      = '0;
            end
        endcase
    end

    // FIFO control: a pop frees the slot a full-FIFO push needs in the same cycle.
    always_comb begin
        pop        = (count_q != 5'd0) && data_ready;
        full       = (count_q == FULL_CNT);
        push       = push_req && (!full || pop);
        overflow_d = push_req && full && !pop;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + 5'(push) - 5'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_prev_q  <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            to_cnt_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            clk_prev_q  <= clk_prev_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            to_cnt_q    <= to_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sh_q[7:0];
        end
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign data_valid = (count_q != 5'd0);
    assign data_out   = data_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: reset checks, table-driven frames, hand sequences for latency/overflow/timeout/reset,
// and randomized frames against a byte-queue reference model.
module tb_ps2_rx;

    localparam int DEPTH = 8;
    localparam int TO    = 300;
    localparam int HALF  = 10;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        bit         bad_par;
        bit         stop;
        int         exp_cnt;
        int         exp_ferr;
        int         exp_perr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       frame_err;
    logic       parity_err;

    logic rdy_man;
    logic rnd_rdy;
    int   total;
    int   bad;
    int   last_drive;

    int         cyc = 0;
    logic       v_prev = 1'b0;
    int         vrise_cyc = -1;
    int         ferr_cyc = -1;
    int         n_ovf = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    logic [7:0] pop_log[$];

    always #5 clk = ~clk;

    ps2_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err),
        .parity_err(parity_err)
    );

    always @(posedge clk) begin
        #2;
        data_ready = rnd_rdy ? ($urandom_range(0, 1) == 1) : rdy_man;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (data_valid && data_ready) pop_log.push_back(data_out);
        if (data_valid && !v_prev) vrise_cyc = cyc;
        v_prev = data_valid;
        if (overflow) n_ovf = n_ovf + 1;
        if (frame_err) begin
            n_ferr   = n_ferr + 1;
            ferr_cyc = cyc;
        end
        if (parity_err) n_perr = n_perr + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par, input bit stop);
        logic par;
        par = ~(^d) ^ bad_par;
        return {stop, par, d, 1'b0};
    endfunction

    function automatic vec_t mk_vec(input logic [7:0] d, input bit bp, input bit st);
        vec_t v;
        v.d        = d;
        v.bad_par  = bp;
        v.stop     = st;
        v.exp_ferr = st ? 0 : 1;
        v.exp_perr = (st && bp && PAR_EN) ? 1 : 0;
        v.exp_cnt  = (st && !(bp && PAR_EN)) ? 1 : 0;
        return v;
    endfunction

    // Device drives data while the clock is high, then pulls the clock low for HALF cycles.
    task automatic send_frame(input logic [10:0] bits, input int nedges, input bit pop_at_done);
        for (int i = 0; i < nedges; i++) begin
            ps2_dat = bits[i];
            tick(HALF);
            ps2_clk    = 1'b0;
            last_drive = cyc;
            if (pop_at_done && i == 10) begin
                tick(3);
                rdy_man = 1'b1;
                tick(1);
                rdy_man = 1'b0;
                tick(HALF - 4);
            end else begin
                tick(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(mk_frame(d, 1'b0, 1'b1), 11, 1'b0);
        tick(10);
    endtask

    task automatic pop_one();
        rdy_man = 1'b1;
        tick(1);
        rdy_man = 1'b0;
        tick(3);
    endtask

    vec_t       tv[6];
    logic [7:0] exp_q[$];

    initial begin
        int base_pop, base_ferr, base_perr, base_ovf, exp_f, exp_p;
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        rdy_man = 1'b0;
        rnd_rdy = 1'b0;
        last_drive = 0;

        tv[0] = mk_vec(8'h5A, 1'b1, 1'b1);
        tv[1] = mk_vec(8'hA5, 1'b0, 1'b0);
        tv[2] = mk_vec(8'h00, 1'b0, 1'b1);
        tv[3] = mk_vec(8'hFF, 1'b0, 1'b1);
        tv[4] = mk_vec(8'h3C, 1'b1, 1'b0);
        tv[5] = mk_vec(8'h80, 1'b0, 1'b1);

        tick(4);
        chk("rst_valid", int'(data_valid), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_pulses", int'({overflow, frame_err, parity_err}), 0);
        rst = 1'b0;
        tick(5);

        // Single frame, consumer stalled: latency and hold.
        send_frame(mk_frame(8'h1C, 1'b0, 1'b1), 11, 1'b0);
        chk("lat_valid_rise", vrise_cyc - last_drive, 5);
        chk("lat_data", int'(data_out), 8'h1C);
        chk("lat_count", int'(fifo_count), 1);
        tick(20);
        chk("hold_data", int'(data_out), 8'h1C);
        base_pop = pop_log.size();
        pop_one();
        chk("pop1_count", int'(fifo_count), 0);
        chk("pop1_nlog", pop_log.size() - base_pop, 1);
        if (pop_log.size() > base_pop) chk("pop1_byte", int'(pop_log[base_pop]), 8'h1C);
        chk("empty_pop_count", int'(fifo_count), 0);
        pop_one();
        chk("underflow_count", int'(fifo_count), 0);

        // A start bit of 1 must not open a frame.
        base_ferr = n_ferr;
        send_frame(11'h7FF, 1, 1'b0);
        tick(TO + 20);
        chk("start1_count", int'(fifo_count), 0);
        chk("start1_ferr", n_ferr - base_ferr, 0);

        foreach (tv[i]) begin
            base_ferr = n_ferr;
            base_perr = n_perr;
            send_frame(mk_frame(tv[i].d, tv[i].bad_par, tv[i].stop), 11, 1'b0);
            tick(10);
            chk($sformatf("vec%0d_count", i), int'(fifo_count), tv[i].exp_cnt);
            chk($sformatf("vec%0d_ferr", i), n_ferr - base_ferr, tv[i].exp_ferr);
            chk($sformatf("vec%0d_perr", i), n_perr - base_perr, tv[i].exp_perr);
            if (tv[i].exp_cnt == 1) begin
                chk($sformatf("vec%0d_data", i), int'(data_out), int'(tv[i].d));
                pop_one();
            end
        end

        // Back-to-back frames with a free-running consumer.
        base_pop  = pop_log.size();
        base_ferr = n_ferr;
        base_perr = n_perr;
        rdy_man   = 1'b1;
        send_frame(mk_frame(8'hF0, 1'b0, 1'b1), 11, 1'b0);
        send_frame(mk_frame(8'h1C, 1'b0, 1'b1), 11, 1'b0);
        tick(10);
        rdy_man = 1'b0;
        chk("b2b_npops", pop_log.size() - base_pop, 2);
        if (pop_log.size() >= base_pop + 2) begin
            chk("b2b_first", int'(pop_log[base_pop]), 8'hF0);
            chk("b2b_second", int'(pop_log[base_pop + 1]), 8'h1C);
        end
        chk("b2b_errs", (n_ferr - base_ferr) + (n_perr - base_perr), 0);

        // Fill, overflow, then a push that coincides with a pop while full.
        base_ovf = n_ovf;
        base_pop = pop_log.size();
        for (int i = 1; i <= DEPTH; i++) send_byte(8'(i));
        chk("full_count", int'(fifo_count), DEPTH);
        chk("full_no_ovf", n_ovf - base_ovf, 0);
        send_byte(8'h09);
        chk("ovf_pulse", n_ovf - base_ovf, 1);
        chk("ovf_count", int'(fifo_count), DEPTH);
        chk("ovf_head_held", int'(data_out), 8'h01);
        send_frame(mk_frame(8'h0A, 1'b0, 1'b1), 11, 1'b1);
        tick(10);
        chk("fullpop_no_ovf", n_ovf - base_ovf, 1);
        chk("fullpop_count", int'(fifo_count), DEPTH);
        rdy_man = 1'b1;
        tick(20);
        rdy_man = 1'b0;
        chk("drain_npops", pop_log.size() - base_pop, DEPTH + 1);
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (base_pop + i < pop_log.size())
                chk($sformatf("drain_%0d", i), int'(pop_log[base_pop + i]), (i < DEPTH) ? i + 1 : 8'h0A);
        end

        // Timeout after 5 edges.
        base_ferr = n_ferr;
        send_frame(mk_frame(8'h33, 1'b0, 1'b1), 5, 1'b0);
        tick(TO + 40);
        chk("to_ferr", n_ferr - base_ferr, 1);
        chk("to_delay", ferr_cyc - last_drive - 3, TO);
        chk("to_count", int'(fifo_count), 0);
        send_byte(8'h5A);
        chk("to_next_data", int'(data_out), 8'h5A);
        chk("to_next_count", int'(fifo_count), 1);
        pop_one();

        // Reset mid-frame with bytes stored.
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        chk("pre_rst_count", int'(fifo_count), 3);
        send_frame(mk_frame(8'h77, 1'b0, 1'b1), 4, 1'b0);
        base_ferr = n_ferr;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        chk("mrst_count", int'(fifo_count), 0);
        chk("mrst_valid", int'(data_valid), 0);
        send_byte(8'h29);
        chk("mrst_data", int'(data_out), 8'h29);
        chk("mrst_next_count", int'(fifo_count), 1);
        chk("mrst_ferr", n_ferr - base_ferr, 0);
        pop_one();

        // Randomized frames against a queue model of accepted bytes.
        exp_q.delete();
        exp_f     = 0;
        exp_p     = 0;
        base_pop  = pop_log.size();
        base_ferr = n_ferr;
        base_perr = n_perr;
        rnd_rdy   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            bit bs, bp;
            d  = 8'($urandom_range(0, 255));
            bs = ($urandom_range(0, 5) == 0);
            bp = ($urandom_range(0, 3) == 0);
            if (bs) exp_f = exp_f + 1;
            else if (bp && PAR_EN) exp_p = exp_p + 1;
            else exp_q.push_back(d);
            send_frame(mk_frame(d, bp, !bs), 11, 1'b0);
            tick($urandom_range(0, 30));
        end
        tick(20);
        rnd_rdy = 1'b0;
        rdy_man = 1'b1;
        tick(20);
        rdy_man = 1'b0;
        chk("rnd_npops", pop_log.size() - base_pop, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base_pop + i < pop_log.size())
                chk($sformatf("rnd_byte%0d", i), int'(pop_log[base_pop + i]), int'(exp_q[i]));
        end
        chk("rnd_ferr", n_ferr - base_ferr, exp_f);
        chk("rnd_perr", n_perr - base_perr, exp_p);
        chk("rnd_end_count", int'(fifo_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
- REQ-001: Parameter FIFO_DEPTH, default 8, number of received bytes buffered (power of two, 2..16).
- REQ-002: Parameter TIMEOUT_CYCLES, default 50000, idle clk cycles allowed between PS/2 clock falling edges inside a frame (1 ms at 50 MHz).
- REQ-003: clk  input  1  system clock; every register of the block is clocked on its rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: ps2_clk  input  1  asynchronous PS/2 clock from the keyboard, idle high.
- REQ-006: ps2_dat  input  1  asynchronous PS/2 data from the keyboard, idle high.
- REQ-007: data_out  output  8  head-of-FIFO scancode byte.
- REQ-008: data_valid  output  1  high while the FIFO is non-empty.
- REQ-009: data_ready  input  1  consumer pop; a byte is popped on any cycle where data_valid && data_ready.
- REQ-010: fifo_count  output  5  number of bytes currently stored.
- REQ-011: overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- REQ-012: frame_err  output  1  one-cycle pulse on bad stop bit or timeout.
- REQ-013: parity_err  output  1  one-cycle pulse on a parity failure (PS2_PARITY_CHECK_EN only; otherwise tied 0).

Function
- REQ-014: ps2_clk and ps2_dat SHALL each pass through a 2-flop synchronizer; a falling edge is detected when the synchronized clock goes 1->0 between consecutive cycles, and ps2_dat is sampled in that same cycle.
- REQ-015: Frame = 11 bits: start (0), 8 data bits LSB first, odd parity, stop (1).
- REQ-016: FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on a falling edge with sampled data 0; a start bit of 1 SHALL be ignored silently (stay IDLE).
- REQ-017: SHIFT SHALL accept 10 further edges (data, parity, stop) and then go to DONE; the edge-to-edge timeout counter is cleared on every edge.
- REQ-018: In SHIFT, if the timeout counter reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE, discard the partial byte, and pulse frame_err.
- REQ-019: DONE lasts exactly one cycle: a stop bit of 0 pulses frame_err and discards the byte; otherwise the byte is pushed (subject to REQ-024); the FSM then returns to IDLE.
- REQ-020: A pushed byte SHALL appear on data_out with data_valid=1 in the cycle after DONE (first-word fall-through); total latency from the stop-bit edge-detect cycle is 2 clk.
- REQ-021: A push and a pop in the same cycle SHALL both occur; fifo_count is unchanged.
- REQ-022: Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
- REQ-023: A pop while empty SHALL be ignored; fifo_count never underflows.
- REQ-024: A push while full with no simultaneous pop SHALL drop the new byte, keep the FIFO unchanged, and pulse overflow; full with a simultaneous pop SHALL accept the push.
- REQ-025: data_out SHALL hold its value while data_valid=1 and data_ready=0.

Reset
- REQ-026: While rst=1: FSM=IDLE, shift register=0, timeout counter=0, FIFO pointers=0, fifo_count=0, data_valid=0, data_out=0, overflow=frame_err=parity_err=0, synchronizer flops=1.
- REQ-027: Reset mid-frame SHALL discard the partial frame; reception restarts at the next start bit after rst deasserts.

Configuration
- REQ-028: Macro PS2_PARITY_CHECK_EN: when defined, DONE SHALL check odd parity over data+parity bits; on failure, drop the byte and pulse parity_err (frame_err takes precedence if the stop bit is also bad, with only frame_err pulsing).
- REQ-029: When PS2_PARITY_CHECK_EN is undefined, the parity bit is shifted in but ignored, every byte with a good stop bit is pushed, and parity_err is constant 0.

Verification
- REQ-030: Frame 0x1C, parity 0, stop 1, data_ready=0 -> data_out=0x1C, data_valid=1, fifo_count=1 exactly 2 clk after the stop-bit edge detect.
- REQ-031: Frames 0xF0 then 0x1C back-to-back, data_ready=1 -> two single-cycle pops in order 0xF0, 0x1C, no error pulses.
- REQ-032: Frame 0x5A with parity 0 (PS2_PARITY_CHECK_EN defined) -> one parity_err pulse, fifo_count stays 0; without the macro -> 0x5A pushed.
- REQ-033: 9 good frames 0x01..0x09, data_ready=0 -> fifo_count=8, one overflow pulse on the 9th frame, pops return 0x01..0x08.
- REQ-034: 5 edges, then ps2_clk held high -> frame_err pulses exactly TIMEOUT_CYCLES cycles after the last edge; a following 0x5A frame is received correctly.
- REQ-035: rst=1 for 1 cycle after the 4th edge, with 3 bytes stored -> fifo_count=0, data_valid=0; the next full 0x29 frame is received as 0x29.
